// File: rtl/alu_shift_pkg.sv
// Shared definitions for the sequential shift unit: operation codes,
// FSM state encoding and default widths.
package alu_shift_pkg;

    localparam int DATA_W_DEF  = 32;
    localparam int SHAMT_W_DEF = 5;
    // Stage counter width; it must also hold the value SHAMT_W after the last stage.
    localparam int CNT_W       = 3;

    localparam logic [1:0] SH_SLL = 2'b00;
    localparam logic [1:0] SH_SRL = 2'b01;
    localparam logic [1:0] SH_SRA = 2'b11;
    // 2'b10 is reserved and executes as SRL.

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_e;

endpackage

// File: rtl/alu_shift_stage.sv
// One conditional log-shifter stage: shifts d_i by 2**k_i when en_i is set.
// All candidate shift distances are built in parallel and one is picked by k_i.
module alu_shift_stage
    import alu_shift_pkg::*;
#(
    parameter int DATA_W  = DATA_W_DEF,
    parameter int SHAMT_W = SHAMT_W_DEF
) (
    input  logic [DATA_W-1:0] d_i,
    input  logic [CNT_W-1:0]  k_i,
    input  logic              en_i,
    input  logic [1:0]        op_i,
    output logic [DATA_W-1:0] q_o
);

    logic [DATA_W-1:0] sll_s [SHAMT_W];
    logic [DATA_W-1:0] srl_s [SHAMT_W];
    logic [DATA_W-1:0] sra_s [SHAMT_W];

    for (genvar gi = 0; gi < SHAMT_W; gi++) begin : g_dist
        assign sll_s[gi] = d_i << (2 ** gi);
        assign srl_s[gi] = d_i >> (2 ** gi);
        assign sra_s[gi] = $unsigned($signed(d_i) >>> (2 ** gi));
    end

    // Pick the shifted value for the requested distance; bypass otherwise.
    always_comb begin
        q_o = d_i;
        if (en_i) begin
            for (int i = 0; i < SHAMT_W; i++) begin
                if (k_i == CNT_W'(i)) begin
                    case (op_i)
                        SH_SLL:  q_o = sll_s[i];
                        SH_SRA:  q_o = sra_s[i];
                        default: q_o = srl_s[i];
                    endcase
                end
            end
        end
    end

endmodule

// File: rtl/alu_shift_seq.sv
// Multi-cycle SLL/SRL/SRA unit: one shifter stage reused over the shift-amount
// bits, valid/ready on both sides.
// Optional macro ALU_SHIFT_SEQ_EARLY_EXIT_EN: finish as soon as no higher
// shift-amount bits remain (results identical, latency shorter).
module alu_shift_seq
    import alu_shift_pkg::*;
#(
    parameter int DATA_W  = DATA_W_DEF,
    parameter int SHAMT_W = SHAMT_W_DEF
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              flush_i,
    input  logic              valid_i,
    output logic              ready_o,
    input  logic [1:0]        op_i,
    input  logic [DATA_W-1:0] a_i,
    input  logic [DATA_W-1:0] b_i,
    output logic              valid_o,
    input  logic              ready_i,
    output logic [DATA_W-1:0] c_o,
    output logic              busy_o
);

    state_e              state_q, state_d;
    logic [DATA_W-1:0]   acc_q, acc_d;
    logic [SHAMT_W-1:0]  shamt_q, shamt_d;
    logic [1:0]          op_q, op_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;

    logic [DATA_W-1:0]   stage_out;
    logic [SHAMT_W-1:0]  shamt_sh;
    logic                last_stage;

    // Bit 0 of shamt_sh is the enable of the current stage; the rest are the
    // bits still to come.
    assign shamt_sh = shamt_q >> cnt_q;

`ifdef ALU_SHIFT_SEQ_EARLY_EXIT_EN
    assign last_stage = (cnt_q == CNT_W'(SHAMT_W - 1)) || (shamt_sh[SHAMT_W-1:1] == '0);
`else
    assign last_stage = (cnt_q == CNT_W'(SHAMT_W - 1));
`endif

    alu_shift_stage #(
        .DATA_W  (DATA_W),
        .SHAMT_W (SHAMT_W)
    ) u_stage (
        .d_i  (acc_q),
        .k_i  (cnt_q),
        .en_i (shamt_sh[0]),
        .op_i (op_q),
        .q_o  (stage_out)
    );

    assign ready_o = (state_q == ST_IDLE) && !rst_i;
    assign valid_o = (state_q == ST_DONE);
    assign busy_o  = (state_q != ST_IDLE);
    assign c_o     = acc_q;

    // Next-state logic: accept in IDLE, one stage per SHIFT cycle, hold in DONE.
    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        shamt_d = shamt_q;
        op_d    = op_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (valid_i) begin
                    acc_d   = a_i;
                    shamt_d = b_i[SHAMT_W-1:0];
                    op_d    = op_i;
                    cnt_d   = '0;
                    state_d = ST_SHIFT;
`ifdef ALU_SHIFT_SEQ_EARLY_EXIT_EN
                    if (b_i[SHAMT_W-1:0] == '0) begin
                        state_d = ST_DONE;
                    end
`endif
                end
            end
            ST_SHIFT: begin
                acc_d = stage_out;
                cnt_d = cnt_q + CNT_W'(1);
                if (last_stage) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                if (ready_i) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State registers: reset clears everything, flush only aborts to IDLE.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
            acc_q   <= '0;
            shamt_q <= '0;
            op_q    <= '0;
            cnt_q   <= '0;
        end else if (flush_i) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            shamt_q <= shamt_d;
            op_q    <= op_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule

// File: tb/tb_alu_shift_seq.sv
// Self-checking bench for alu_shift_seq: directed cases, random operations
// against an arithmetic reference, result stall, flush and reset aborts.
module tb_alu_shift_seq;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic        flush_i = 1'b0;
    logic        valid_i = 1'b0;
    logic        ready_o;
    logic [1:0]  op_i = 2'b00;
    logic [31:0] a_i = '0;
    logic [31:0] b_i = '0;
    logic        valid_o;
    logic        ready_i = 1'b0;
    logic [31:0] c_o;
    logic        busy_o;

    int checks = 0;
    int errors = 0;

    always #5 clk_i = ~clk_i;

    alu_shift_seq dut (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .flush_i (flush_i),
        .valid_i (valid_i),
        .ready_o (ready_o),
        .op_i    (op_i),
        .a_i     (a_i),
        .b_i     (b_i),
        .valid_o (valid_o),
        .ready_i (ready_i),
        .c_o     (c_o),
        .busy_o  (busy_o)
    );

    // Reference result from plain shift operators.
    function automatic logic [31:0] ref_shift(input logic [1:0] op, input logic [31:0] a,
                                              input logic [31:0] b);
        int s;
        s = int'(b % 32);
        case (op)
            2'b00:   return a << s;
            2'b11:   return $unsigned($signed(a) >>> s);
            default: return a >> s;
        endcase
    endfunction

    // Reference latency: edges from the accept edge (counted as 1) to valid_o.
    function automatic int ref_lat(input logic [31:0] b);
        int s;
        int msb;
        s = int'(b % 32);
`ifdef ALU_SHIFT_SEQ_EARLY_EXIT_EN
        if (s == 0) return 1;
        msb = 0;
        for (int i = 0; i < 5; i++) if (((s >> i) & 1) == 1) msb = i;
        return 2 + msb;
`else
        msb = s;
        return 6;
`endif
    endfunction

    // Issue one request, wait for the result and consume it.
    task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                          output int lat, output logic [31:0] res, output bit rdy_ok,
                          output bit busy_ok);
        int n;
        @(negedge clk_i);
        rdy_ok = ready_o;
        valid_i = 1'b1; op_i = op; a_i = a; b_i = b; ready_i = 1'b1;
        @(negedge clk_i);
        valid_i = 1'b0;
        busy_ok = 1'b1;
        n = 1;
        while (!valid_o && n < 20) begin
            if (!busy_o) busy_ok = 1'b0;
            @(negedge clk_i);
            n++;
        end
        if (!busy_o) busy_ok = 1'b0;
        lat = valid_o ? n : -1;
        res = c_o;
        @(negedge clk_i);
        ready_i = 1'b0;
    endtask

    task automatic test_reset();
        rst_i = 1'b1;
        repeat (2) @(negedge clk_i);
        checks++;
        if (ready_o !== 1'b0) begin errors++; $display("FAIL reset_ready: got %b want 0", ready_o); end
        checks++;
        if (valid_o !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", valid_o); end
        checks++;
        if (busy_o !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy_o); end
        checks++;
        if (c_o !== 32'h0) begin errors++; $display("FAIL reset_c: got %h want 0", c_o); end
        rst_i = 1'b0;
        @(negedge clk_i);
        checks++;
        if (ready_o !== 1'b1) begin errors++; $display("FAIL idle_ready: got %b want 1", ready_o); end
        $display("reset: done");
    endtask

    task automatic test_directed();
        logic [1:0]  ops [8] = '{2'b00, 2'b11, 2'b01, 2'b10, 2'b01, 2'b00, 2'b00, 2'b00};
        logic [31:0] as  [8] = '{32'h1, 32'h8000_0000, 32'h8000_0000, 32'h8000_0000,
                                 32'h1234_5678, 32'hF, 32'hF, 32'hFFFF_FFFF};
        logic [31:0] bs  [8] = '{32'd31, 32'd4, 32'd4, 32'd4, 32'h20, 32'd1, 32'h10, 32'hFFFF_FFE0};
        int lat;
        logic [31:0] res, exp_c;
        bit rdy_ok, busy_ok;
        for (int i = 0; i < 8; i++) begin
            run_op(ops[i], as[i], bs[i], lat, res, rdy_ok, busy_ok);
            exp_c = ref_shift(ops[i], as[i], bs[i]);
            checks++;
            if (res !== exp_c) begin errors++; $display("FAIL dir%0d_result: got %h want %h", i, res, exp_c); end
            checks++;
            if (lat != ref_lat(bs[i])) begin errors++; $display("FAIL dir%0d_latency: got %0d want %0d", i, lat, ref_lat(bs[i])); end
            checks++;
            if (!(rdy_ok && busy_ok)) begin errors++; $display("FAIL dir%0d_handshake: ready %b busy %b want 1 1", i, rdy_ok, busy_ok); end
            $display("directed %0d: op=%b a=%h b=%h c=%h lat=%0d", i, ops[i], as[i], bs[i], res, lat);
        end
    endtask

    task automatic test_random();
        int lat;
        logic [31:0] res, exp_c, a, b;
        logic [1:0] op;
        bit rdy_ok, busy_ok;
        for (int i = 0; i < 40; i++) begin
            a = $urandom; b = $urandom; op = 2'($urandom_range(0, 3));
            if (i % 4 == 0) b = b & 32'hFFFF_FFE0;
            if (i % 4 == 1) a = a | 32'h8000_0000;
            run_op(op, a, b, lat, res, rdy_ok, busy_ok);
            exp_c = ref_shift(op, a, b);
            checks++;
            if (res !== exp_c) begin errors++; $display("FAIL rnd%0d_result: got %h want %h", i, res, exp_c); end
            checks++;
            if (lat != ref_lat(b)) begin errors++; $display("FAIL rnd%0d_latency: got %0d want %0d", i, lat, ref_lat(b)); end
            $display("random %0d: op=%b a=%h b=%h c=%h lat=%0d", i, op, a, b, res, lat);
        end
    endtask

    task automatic test_stall();
        int n;
        logic [31:0] exp2;
        exp2 = ref_shift(2'b01, 32'hF0F0_0000, 32'd8);
        @(negedge clk_i);
        valid_i = 1'b1; op_i = 2'b00; a_i = 32'h1; b_i = 32'd31; ready_i = 1'b0;
        @(negedge clk_i);
        valid_i = 1'b0;
        n = 1;
        while (!valid_o && n < 20) begin @(negedge clk_i); n++; end
        checks++;
        if (!valid_o) begin errors++; $display("FAIL stall_timeout: valid_o %b want 1", valid_o); end
        valid_i = 1'b1; op_i = 2'b01; a_i = 32'hF0F0_0000; b_i = 32'd8;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk_i);
            checks++;
            if (!(valid_o === 1'b1 && c_o === 32'h8000_0000 && ready_o === 1'b0)) begin
                errors++;
                $display("FAIL stall_hold%0d: valid %b c %h ready %b want 1 80000000 0", i, valid_o, c_o, ready_o);
            end
        end
        ready_i = 1'b1;
        @(negedge clk_i);
        checks++;
        if (!(ready_o === 1'b1 && valid_o === 1'b0 && busy_o === 1'b0)) begin
            errors++;
            $display("FAIL stall_idle: ready %b valid %b busy %b want 1 0 0", ready_o, valid_o, busy_o);
        end
        @(negedge clk_i);
        valid_i = 1'b0;
        n = 1;
        while (!valid_o && n < 20) begin @(negedge clk_i); n++; end
        checks++;
        if (!(valid_o === 1'b1 && c_o === exp2)) begin errors++; $display("FAIL stall_second: valid %b c %h want 1 %h", valid_o, c_o, exp2); end
        checks++;
        if (n != ref_lat(32'd8)) begin errors++; $display("FAIL stall_second_lat: got %0d want %0d", n, ref_lat(32'd8)); end
        @(negedge clk_i);
        ready_i = 1'b0;
        $display("stall: first held 3 cycles, second c=%h lat=%0d", c_o, n);
    endtask

    // Abort on the second SHIFT cycle with flush (use_rst=0) or reset (use_rst=1).
    task automatic test_abort(input bit use_rst);
        bit saw_valid;
        int lat;
        logic [31:0] res, exp_c;
        bit rdy_ok, busy_ok;
        @(negedge clk_i);
        valid_i = 1'b1; op_i = 2'b11; a_i = 32'h8765_4321; b_i = 32'h13; ready_i = 1'b1;
        @(negedge clk_i);
        valid_i = 1'b0;
        @(negedge clk_i);
        if (use_rst) rst_i = 1'b1; else flush_i = 1'b1;
        @(negedge clk_i);
        if (use_rst) begin
            checks++;
            if (!(c_o === 32'h0 && ready_o === 1'b0 && busy_o === 1'b0 && valid_o === 1'b0)) begin
                errors++;
                $display("FAIL rst_abort: c %h ready %b busy %b valid %b want 0 0 0 0", c_o, ready_o, busy_o, valid_o);
            end
            rst_i = 1'b0;
        end else begin
            flush_i = 1'b0;
            checks++;
            if (!(ready_o === 1'b1 && busy_o === 1'b0 && valid_o === 1'b0)) begin
                errors++;
                $display("FAIL flush_abort: ready %b busy %b valid %b want 1 0 0", ready_o, busy_o, valid_o);
            end
        end
        saw_valid = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk_i);
            if (valid_o) saw_valid = 1'b1;
        end
        checks++;
        if (saw_valid) begin errors++; $display("FAIL abort%0d_no_valid: valid pulse seen, want none", use_rst); end
        if (use_rst) begin
            checks++;
            if (c_o !== 32'h0) begin errors++; $display("FAIL rst_c_after: got %h want 0", c_o); end
        end
        run_op(2'b00, 32'h0000_ABCD, 32'd12, lat, res, rdy_ok, busy_ok);
        exp_c = ref_shift(2'b00, 32'h0000_ABCD, 32'd12);
        checks++;
        if (!(res === exp_c && lat == ref_lat(32'd12) && rdy_ok)) begin
            errors++;
            $display("FAIL abort%0d_next: c %h lat %0d ready %b want %h %0d 1", use_rst, res, lat, rdy_ok, exp_c, ref_lat(32'd12));
        end
        $display("abort (rst=%0d): next op c=%h lat=%0d", use_rst, res, lat);
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_stall();
        test_abort(1'b0);
        test_abort(1'b1);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
